// File: rtl/cplx_bank_seq.sv
// Micro-sequencer for the 16x64 complex register bank: fetches two operands,
// computes MOV/ADD/SUB/MUL on {real, imag} words and writes the result back.
module cplx_bank_seq #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      instr_op,
  input  logic [RW-1:0]   instr_dst,
  input  logic [RW-1:0]   instr_srca,
  input  logic [RW-1:0]   instr_srcb,
  input  logic            instr_cnsta,
  input  logic            instr_cnstb,
  input  logic [1:0]      instr_endw,
  output logic            busy,
  output logic            done,
  output logic            regwen,
  output logic [2*DW-1:0] inA,
  output logic [RW-1:0]   selwreg,
  output logic [1:0]      endwreg,
  output logic [RW-1:0]   seloutA,
  output logic [RW-1:0]   seloutB,
  output logic            cnstA,
  output logic            cnstB,
  output logic            enrregA,
  output logic            enrregB,
  input  logic [2*DW-1:0] outA,
  input  logic [2*DW-1:0] outB
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MUL2 = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_WR2  = 3'd5;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  // Low DW bits of a signed product; identical to truncating the full 2*DW product.
  function automatic logic signed [DW-1:0] mul_lo(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    return a * b;
  endfunction

  function automatic logic signed [DW-1:0] cmul_re(input logic signed [DW-1:0] ar,
                                                   input logic signed [DW-1:0] ai,
                                                   input logic signed [DW-1:0] br,
                                                   input logic signed [DW-1:0] bi);
    return mul_lo(ar, br) - mul_lo(ai, bi);
  endfunction

  function automatic logic signed [DW-1:0] cmul_im(input logic signed [DW-1:0] ar,
                                                   input logic signed [DW-1:0] ai,
                                                   input logic signed [DW-1:0] br,
                                                   input logic signed [DW-1:0] bi);
    return mul_lo(ar, bi) + mul_lo(ai, br);
  endfunction

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q;
  logic [RW-1:0]        dst_q;
  logic [1:0]           endw_q;
  logic signed [DW-1:0] re_q;

  logic                 regwen_q, done_q, enrregA_q, enrregB_q;
  logic [2*DW-1:0]      inA_q;
  logic [RW-1:0]        selwreg_q, seloutA_q, seloutB_q;
  logic [1:0]           endwreg_q;
  logic                 cnstA_q, cnstB_q;

  logic                 accept;
  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [DW-1:0] res_re, res_im;

  assign accept = (state_q == S_IDLE) && instr_valid;

  assign ar = outA[2*DW-1:DW];
  assign ai = outA[DW-1:0];
  assign br = outB[2*DW-1:DW];
  assign bi = outB[DW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_MUL) ? S_MUL2 : S_WR1;
      S_MUL2:  state_d = S_WR1;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result selection: EXEC finishes MOV/ADD/SUB, MUL2 pairs the held real part
  // with the imaginary part computed from the still-held bank outputs.
  always_comb begin
    res_re = ar;
    res_im = ai;
    if (state_q == S_MUL2) begin
      res_re = re_q;
      res_im = cmul_im(ar, ai, br, bi);
    end else begin
      case (op_q)
        OP_ADD: begin
          res_re = ar + br;
          res_im = ai + bi;
        end
        OP_SUB: begin
          res_re = ar - br;
          res_im = ai - bi;
        end
        default: begin
          res_re = ar;
          res_im = ai;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      endw_q    <= '0;
      re_q      <= '0;
      regwen_q  <= 1'b0;
      done_q    <= 1'b0;
      enrregA_q <= 1'b0;
      enrregB_q <= 1'b0;
      inA_q     <= '0;
      selwreg_q <= '0;
      endwreg_q <= '0;
      seloutA_q <= '0;
      seloutB_q <= '0;
      cnstA_q   <= 1'b0;
      cnstB_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Pulse-type outputs decode the upcoming state so they line up with it.
      enrregA_q <= (state_d == S_READ);
      enrregB_q <= (state_d == S_READ);
      regwen_q  <= (state_d == S_WR1) || (state_d == S_WR2);
      done_q    <= (state_d == S_WR2);

      if (accept) begin
        op_q      <= instr_op;
        dst_q     <= instr_dst;
        endw_q    <= instr_endw;
        seloutA_q <= instr_srca;
        seloutB_q <= instr_srcb;
        cnstA_q   <= instr_cnsta;
        cnstB_q   <= instr_cnstb;
      end

      if (state_q == S_EXEC) begin
        re_q <= cmul_re(ar, ai, br, bi);
      end

      // Write data, index and mode are loaded once and held through WR1/WR2.
      if (state_d == S_WR1) begin
        inA_q     <= {res_re, res_im};
        selwreg_q <= dst_q;
        endwreg_q <= endw_q;
      end
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign regwen      = regwen_q;
  assign inA         = inA_q;
  assign selwreg     = selwreg_q;
  assign endwreg     = endwreg_q;
  assign seloutA     = seloutA_q;
  assign seloutB     = seloutB_q;
  assign cnstA       = cnstA_q;
  assign cnstB       = cnstB_q;
  assign enrregA     = enrregA_q;
  assign enrregB     = enrregB_q;

endmodule
